// File: rtl/sync_frame_tx_if.sv
// ---------------------------------------------------------------------------
// sync_frame_tx_if
// Handshake and serial-line bundle for sync_frame_tx.
//   load     producer -> tx : request to send, sampled while ready=1
//   data_in  producer -> tx : payload, captured on the accepting edge
//   ready    tx -> producer : high only while the transmitter is idle
//   o        tx -> line     : registered serial data, MSB first
//   o_valid  tx -> line     : high while a sync or payload bit is on o
//   done     tx -> producer : one-cycle pulse on the first gap cycle
// modport master is the producer/line side, modport slave the transmitter.
// ---------------------------------------------------------------------------
interface sync_frame_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 load;
    logic [DATA_BITS-1:0] data_in;
    logic                 ready;
    logic                 o;
    logic                 o_valid;
    logic                 done;

    modport master (
        output load,
        output data_in,
        input  ready,
        input  o,
        input  o_valid,
        input  done
    );

    modport slave (
        input  load,
        input  data_in,
        output ready,
        output o,
        output o_valid,
        output done
    );
endinterface

// File: rtl/sync_frame_tx.sv
// ---------------------------------------------------------------------------
// sync_frame_tx
// Serial frame transmitter: a fixed sync word followed by a parallel-loaded
// payload, one bit per clock, MSB first, then GAP_BITS idle-zero cycles.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    sync_frame_tx_if.slave (load/data_in in; ready/o/o_valid/done out)
// o, o_valid and done come straight from flops; ready is decoded from the
// state register only, so nothing on the producer side reaches the line
// combinationally.
// ---------------------------------------------------------------------------
module sync_frame_tx #(
    parameter int                   DATA_BITS = 8,
    parameter int                   SYNC_BITS = 4,
    parameter logic [SYNC_BITS-1:0] SYNC_WORD = 4'b1101,
    parameter int                   GAP_BITS  = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    sync_frame_tx_if.slave bus
);
    localparam int MAX_SD   = (SYNC_BITS > DATA_BITS) ? SYNC_BITS : DATA_BITS;
    localparam int MAX_BITS = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS) + 1;
    localparam int SIDX_W   = (SYNC_BITS > 1) ? $clog2(SYNC_BITS) : 1;

    // Counter reload values: each phase counts down to zero, inclusive.
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 o_q, o_d;
    logic                 o_valid_q, o_valid_d;
    logic                 done_q, done_d;
    logic [SIDX_W-1:0]    sync_idx;

    // Outputs are registered one step ahead: the bit computed here is the
    // bit that appears on o in the cycle after the edge, so the counter
    // value for the *next* sync bit is cnt_q - 1.
    assign sync_idx = SIDX_W'(cnt_q - 1'b1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        o_d       = 1'b0;
        o_valid_d = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d   = SYNC;
                    cnt_d     = SYNC_LAST;
                    shift_d   = bus.data_in;
                    o_d       = SYNC_WORD[SYNC_BITS-1];
                    o_valid_d = 1'b1;
                end
            end

            SYNC: begin
                o_valid_d = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    // Sync LSB is on the line now; next up is payload MSB.
                    state_d = DATA;
                    cnt_d   = DATA_LAST;
                    o_d     = shift_q[DATA_BITS-1];
                    shift_d = shift_q << 1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    o_d   = SYNC_WORD[sync_idx];
                end
            end

            DATA: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = GAP;
                    cnt_d   = GAP_LAST;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    o_d       = shift_q[DATA_BITS-1];
                    o_valid_d = 1'b1;
                    shift_d   = shift_q << 1;
                end
            end

            GAP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sync_frame_tx
// Self-checking bench for sync_frame_tx (default parameters: 8-bit payload,
// 1101 sync, one gap cycle). Expected serial frames come from a constant
// table and are queued when a frame is launched; a negedge monitor pops and
// compares every valid bit, checks done framing, idle-line behaviour and a
// 1101 detector model fed from o.
// ---------------------------------------------------------------------------
module tb_sync_frame_tx;
    logic clk;
    logic n_rst;

    sync_frame_tx_if #(.DATA_BITS(8)) bus ();

    sync_frame_tx #(
        .DATA_BITS (8),
        .SYNC_BITS (4),
        .SYNC_WORD (4'b1101),
        .GAP_BITS  (1)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [11:0] frame;
        bit          det_chk;
    } vec_t;

    vec_t tbl [5];

    // Scoreboard and monitor state
    bit   exp_q[$];
    int   rise_cyc[$];
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   idx       = 0;
    int   frame_det = 0;
    int   det_at    = -1;
    bit   det_check = 0;
    bit   prev_valid = 0;
    logic [2:0] hist = 3'b000;

    always @(negedge clk) begin
        logic det;
        cyc++;
        if (!n_rst) begin
            prev_valid = 0;
            idx        = 0;
            frame_det  = 0;
            hist       = 3'b000;
        end else begin
            det = ({hist, bus.o} == 4'b1101);
            if (bus.ready) begin
                check("idle_o", 32'(bus.o), 32'd0);
                check("idle_valid", 32'(bus.o_valid), 32'd0);
            end
            if (bus.o_valid) begin
                if (!prev_valid) begin
                    rise_cyc.push_back(cyc);
                    idx       = 0;
                    frame_det = 0;
                    det_at    = -1;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_bit: got o_valid=1 o=%0b expected no frame at %0t", bus.o, $time);
                end else begin
                    check("serial_bit", 32'(bus.o), 32'(exp_q.pop_front()));
                end
                if (det) begin
                    frame_det++;
                    det_at = idx;
                end
                check("done_in_frame", 32'(bus.done), 32'd0);
                idx++;
            end else if (prev_valid) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("frame_len", 32'(idx), 32'd12);
                if (det_check) begin
                    check("det_count", 32'(frame_det), 32'd1);
                    check("det_pos", 32'(det_at), 32'd3);
                end
            end else begin
                check("done_spurious", 32'(bus.done), 32'd0);
            end
            if (bus.done) done_cnt++;
            hist       = {hist[1:0], bus.o};
            prev_valid = bus.o_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    // Pulse load for one edge and queue the expected serial frame.
    task automatic start_frame(input logic [7:0] d, input logic [11:0] f);
        wait_ready();
        bus.load    = 1'b1;
        bus.data_in = d;
        for (int b = 11; b >= 0; b--) exp_q.push_back(f[b]);
        @(posedge clk); #1;
        bus.load    = 1'b0;
        bus.data_in = ~d;
    endtask

    // Called #1 after the accepting edge: ready must return at edge 13.
    task automatic finish_frame();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'd13);
    endtask

    initial begin
        int d0;
        int base;
        int n;

        tbl[0] = '{data: 8'hA5, frame: 12'b1101_10100101, det_chk: 1'b0};
        tbl[1] = '{data: 8'h00, frame: 12'b1101_00000000, det_chk: 1'b1};
        tbl[2] = '{data: 8'hFF, frame: 12'b1101_11111111, det_chk: 1'b0};
        tbl[3] = '{data: 8'h81, frame: 12'b1101_10000001, det_chk: 1'b0};
        tbl[4] = '{data: 8'h3C, frame: 12'b1101_00111100, det_chk: 1'b0};

        n_rst       = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 8'h00;
        #3;
        check("rst_o", 32'(bus.o), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        #9 n_rst = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            det_check = tbl[i].det_chk;
            d0 = done_cnt;
            start_frame(tbl[i].data, tbl[i].frame);
            check("first_valid", 32'(bus.o_valid), 32'd1);
            finish_frame();
            check("done_once", 32'(done_cnt - d0), 32'd1);
            det_check = 1'b0;
            $display("frame data=%02h sent", tbl[i].data);
        end

        // Loads while busy are ignored
        start_frame(8'h3C, 12'b1101_00111100);
        for (int c = 1; c <= 12; c++) begin
            bus.load    = (c == 3 || c == 8);
            bus.data_in = 8'hC3;
            @(posedge clk); #1;
        end
        bus.load = 1'b0;
        wait_ready();
        repeat (20) @(posedge clk);
        #1;
        check("ignore_flushed", 32'(exp_q.size()), 32'd0);
        $display("busy-load ignore sequence done");

        // Asynchronous reset in the middle of the payload
        start_frame(8'hA5, 12'b1101_10100101);
        repeat (6) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_o", 32'(bus.o), 32'd0);
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        exp_q.delete();
        @(posedge clk); #1 n_rst = 1'b1;
        start_frame(8'h81, 12'b1101_10000001);
        finish_frame();
        $display("mid-frame reset sequence done");

        // load held high: one frame every 14 cycles
        wait_ready();
        base = rise_cyc.size();
        bus.load    = 1'b1;
        bus.data_in = 8'h5A;
        for (int k = 0; k < 3; k++)
            for (int b = 11; b >= 0; b--) exp_q.push_back(b == 11 || b == 10 || b == 8 ||
                                                          b == 6 || b == 4 || b == 3 || b == 1);
        n = 0;
        while (rise_cyc.size() < base + 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.load = 1'b0;
        check("b2b_frames", 32'(rise_cyc.size() - base), 32'd3);
        if (rise_cyc.size() >= base + 3) begin
            check("b2b_gap1", 32'(rise_cyc[base+1] - rise_cyc[base]), 32'd14);
            check("b2b_gap2", 32'(rise_cyc[base+2] - rise_cyc[base+1]), 32'd14);
        end
        wait_ready();
        repeat (20) @(posedge clk);
        #1;
        check("final_flushed", 32'(exp_q.size()), 32'd0);
        $display("back-to-back sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
Serial frame transmitter. It emits a fixed sync word (default 1101) followed by a parallel-loaded payload, one bit per clock, MSB first. It is the transmit-side counterpart of the team's 1101 serial sequence detector: the detector locks onto the sync word this block drives. It sits between a parallel producer (load/ready handshake) and a 1-bit serial line.

Parameters:
DATA_BITS, 8, payload width in bits (>=1)
SYNC_BITS, 4, sync word length in bits (>=1)
SYNC_WORD, 4'b1101, sync pattern, sent MSB first
GAP_BITS, 1, idle-zero cycles driven after each frame (>=1)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
load  input  1  request to send; sampled on clk rise while ready=1
data_in  input  DATA_BITS  payload; captured on the accepting edge
ready  output  1  high only in IDLE; block accepts load
o  output  1  registered serial data out
o_valid  output  1  registered; high while a sync or payload bit is on o
done  output  1  registered one-cycle pulse, first GAP cycle of each frame

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, o=0, o_valid=0, done=0, ready=1, bit counter=0, shift register=0. Takes effect immediately, including mid-frame; the frame is abandoned and never resumed.
- ready is decoded from the state: ready=1 if and only if state=IDLE.
- States: IDLE, SYNC, DATA, GAP.
- IDLE: o=0, o_valid=0. On an edge with load=1:
  - capture data_in into the shift register;
  - go to SYNC, with o=SYNC_WORD[SYNC_BITS-1] and o_valid=1 from that edge onward.
  - load=0 keeps the block in IDLE.
- SYNC: drives SYNC_WORD bits MSB to LSB, one per cycle, SYNC_BITS cycles total. After the LSB go to DATA, with o=payload MSB.
- DATA: drives the captured payload MSB to LSB, DATA_BITS cycles total. After the LSB:
  - go to GAP;
  - o=0, o_valid=0, done=1 for the first GAP cycle only.
- GAP: o=0, o_valid=0 for GAP_BITS cycles, then IDLE.
- Latency and length:
  - the accepting edge k produces the first sync bit on o during cycle k;
  - a frame occupies SYNC_BITS+DATA_BITS cycles of o_valid=1, then GAP_BITS cycles of 0;
  - ready returns at edge k+SYNC_BITS+DATA_BITS+GAP_BITS.
- load while ready=0 is ignored: no queuing and no effect on the frame in flight. data_in changes after the accepting edge do not affect the frame.
- Back-to-back: holding load=1 continuously gives one frame per SYNC_BITS+DATA_BITS+GAP_BITS+1 cycles, because one IDLE cycle always separates frames.
- Counter: one down-counter of width clog2(max(SYNC_BITS,DATA_BITS,GAP_BITS))+1. It reloads on each state entry, and the state advances when it reaches its terminal count. No wrap-around beyond the terminal count.
- Payload content is not scrubbed. A payload containing the sync pattern is transmitted verbatim; framing is the receiver's concern.
- All outputs come from flops; there are no combinational paths from load or data_in to o, o_valid or done.

Test Plan:
1. Reset release, load=1, data_in=8'hA5 at edge 0 -> o over cycles 0..11 = 1,1,0,1,1,0,1,0,0,1,0,1; o_valid=1 for cycles 0..11; cycle 12: o=0, o_valid=0, done=1; ready=1 from edge 13.
2. data_in=8'h00, then 8'hFF -> payload bits all 0, then all 1; the sync word is unchanged; done pulses exactly once per frame.
3. Accept 8'h3C, then pulse load with data_in=8'hC3 at cycles 3 and 8 -> the frame carries 8'h3C only; no second frame starts.
4. Assert n_rst=0 mid-payload (cycle 6) -> o=0, o_valid=0, done=0 and ready=1 immediately, before the next clock edge; after release, load=1 with 8'h81 -> complete fresh frame 1101_10000001.
5. load held high with 8'h5A -> frames start at edges 0, 14, 28; one idle cycle (ready=1, o=0) between GAP and the next sync.
6. Loopback into the 1101 sequence detector, payload 8'h00 -> detector output pulses exactly once per frame, during the cycle the last sync bit (cycle 3) is driven.
